// File: rtl/noc_pkg.sv
// Shared definitions for the 5-port XY mesh router.
// Port indices, flit field positions, route and round-robin helpers.
package noc_pkg;

   localparam int NUM_PORTS = 5;

   typedef logic [2:0] port_t;

   localparam port_t PORT_N = 3'd0;
   localparam port_t PORT_E = 3'd1;
   localparam port_t PORT_S = 3'd2;
   localparam port_t PORT_W = 3'd3;
   localparam port_t PORT_L = 3'd4;

   typedef struct packed {
      logic  gnt;
      port_t idx;
   } rr_t;

   function automatic int dest_x_lsb(input int data_w, input int coord_w);
      return data_w - coord_w;
   endfunction

   function automatic int dest_y_lsb(input int data_w, input int coord_w);
      return data_w - 2 * coord_w;
   endfunction

   // Dimension-order: resolve X fully before Y.
   function automatic port_t xy_route(
      input logic [7:0] dx,
      input logic [7:0] dy,
      input logic [7:0] mx,
      input logic [7:0] my
   );
      port_t r;
      if (dx > mx)      r = PORT_E;
      else if (dx < mx) r = PORT_W;
      else if (dy > my) r = PORT_N;
      else if (dy < my) r = PORT_S;
      else              r = PORT_L;
      return r;
   endfunction

   // Descending scan so the requester closest to ptr is written last.
   function automatic rr_t rr_select(
      input logic [NUM_PORTS-1:0] req,
      input port_t                ptr
   );
      rr_t r;
      int  k;
      r = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % NUM_PORTS;
         if (req[k]) begin
            r.gnt = 1'b1;
            r.idx = port_t'(k);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/noc_fifo.sv
// Synchronous input FIFO with registered occupancy count.
// full/empty derive only from registered state.
module noc_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count == CW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/noc_router.sv
// 5-port mesh router: input FIFOs, XY routing, per-output
// round-robin arbitration and registered valid/ready outputs.
module noc_router
   import noc_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int COORD_W    = 2,
   parameter int MY_X       = 0,
   parameter int MY_Y       = 0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_PORTS*DATA_W-1:0] in_data,
   input  logic [NUM_PORTS-1:0]        in_valid,
   output logic [NUM_PORTS-1:0]        in_ready,
   output logic [NUM_PORTS*DATA_W-1:0] out_data,
   output logic [NUM_PORTS-1:0]        out_valid,
   input  logic [NUM_PORTS-1:0]        out_ready
);

   localparam int XL = dest_x_lsb(DATA_W, COORD_W);
   localparam int YL = dest_y_lsb(DATA_W, COORD_W);

   logic [DATA_W-1:0]    head [NUM_PORTS];
   port_t                route [NUM_PORTS];
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] empty;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] req [NUM_PORTS];
   logic [NUM_PORTS-1:0] gnt;
   port_t                gnt_idx [NUM_PORTS];

   assign in_ready = ~full;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
      noc_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (in_valid[p] & ~full[p]),
         .pop   (pop[p]),
         .data  (in_data[p*DATA_W +: DATA_W]),
         .head  (head[p]),
         .full  (full[p]),
         .empty (empty[p])
      );

      assign route[p] = xy_route(
         8'(head[p][XL +: COORD_W]),
         8'(head[p][YL +: COORD_W]),
         8'(MY_X),
         8'(MY_Y)
      );
   end

   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         req[o] = '0;
         for (int p = 0; p < NUM_PORTS; p++)
            req[o][p] = ~empty[p] && (route[p] == port_t'(o));
      end
   end

   // Each input targets one output, so at most one grant pops it.
   always_comb begin
      pop = '0;
      for (int o = 0; o < NUM_PORTS; o++)
         for (int p = 0; p < NUM_PORTS; p++)
            if (gnt[o] && gnt_idx[o] == port_t'(p)) pop[p] = 1'b1;
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      rr_t               sel;
      port_t             rr_ptr;
      logic [DATA_W-1:0] data_q;
      logic              vld_q;
      logic              free;

      assign free       = ~vld_q | out_ready[o];
      assign sel        = rr_select(req[o], rr_ptr);
      assign gnt[o]     = sel.gnt & free;
      assign gnt_idx[o] = sel.idx;

      assign out_data[o*DATA_W +: DATA_W] = data_q;
      assign out_valid[o]                 = vld_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            rr_ptr <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
         end else if (gnt[o]) begin
            rr_ptr <= (sel.idx == PORT_L) ? PORT_N : sel.idx + 3'd1;
            data_q <= head[sel.idx];
            vld_q  <= 1'b1;
         end else if (out_ready[o]) begin
            vld_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_noc_router.sv
// Directed bench for noc_router at mesh position (1,1).
// Expected flits are built from fixed headers and sequence tags.
module tb_noc_router;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [5*DW-1:0] in_data;
   logic [4:0]    in_valid;
   logic [4:0]    in_ready;
   logic [5*DW-1:0] out_data;
   logic [4:0]    out_valid;
   logic [4:0]    out_ready;

   int errors = 0;
   int checks = 0;
   int acc;
   int k;
   logic hs;
   logic [5*DW-1:0] exp_v;

   logic [15:0] rt_hdr [5] = '{16'hF123, 16'h3456, 16'h7ABC, 16'h4DEF, 16'h5001};
   logic [4:0]  rt_vld [5] = '{5'b00010, 5'b01000, 5'b00001, 5'b00100, 5'b10000};
   int          rt_out [5] = '{1, 3, 0, 2, 4};
   int          ord    [4] = '{0, 2, 3, 4};

   always #5 clk = ~clk;

   noc_router #(
      .DATA_W     (DW),
      .FIFO_DEPTH (4),
      .COORD_W    (2),
      .MY_X       (1),
      .MY_Y       (1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] flit(input logic [3:0] h, input int p, input int s);
      return {h, 4'(p), 8'(s)};
   endfunction

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 5'h1f;

      // reset
      tick(); tick(); tick();
      chk("rst_valid", 80'(out_valid), 80'(0));
      chk("rst_data", out_data, 80'(0));
      reset = 1'b0;
      tick();
      chk("rst_ready", 80'(in_ready), 80'(5'h1f));

      // routing from L
      for (int i = 0; i < 5; i++) begin
         in_data[4*DW +: DW] = rt_hdr[i];
         in_valid = 5'b10000;
         tick();
         in_valid = '0;
         chk($sformatf("route%0d_t1", i), 80'(out_valid), 80'(0));
         tick();
         chk($sformatf("route%0d_vld", i), 80'(out_valid), 80'(rt_vld[i]));
         chk($sformatf("route%0d_data", i),
             80'(out_data[rt_out[i]*DW +: DW]), 80'(rt_hdr[i]));
      end
      tick();

      // contention on E
      for (int c = 0; c < 18; c++) begin
         if (c < 4) begin
            for (int j = 0; j < 4; j++)
               in_data[ord[j]*DW +: DW] = flit(4'hC, ord[j], c);
            in_valid = 5'b11101;
         end else begin
            in_valid = '0;
         end
         tick();
         if (c >= 1 && c <= 16) begin
            k = c - 1;
            chk($sformatf("cont%0d_vld", k), 80'(out_valid[1]), 80'(1));
            chk($sformatf("cont%0d_data", k), 80'(out_data[DW +: DW]),
                80'(flit(4'hC, ord[k % 4], k / 4)));
         end else if (c == 17) begin
            chk("cont_idle", 80'(out_valid[1]), 80'(0));
         end
      end

      // back-pressure on L
      out_ready = 5'b01111;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_data[0 +: DW] = flit(4'h5, 0, acc);
         in_valid = 5'b00001;
         hs = in_ready[0];
         tick();
         if (hs) acc++;
      end
      in_valid = '0;
      chk("bp_accepted", 80'(acc), 80'(5));
      chk("bp_in_ready", 80'(in_ready[0]), 80'(0));
      chk("bp_vld", 80'(out_valid[4]), 80'(1));
      chk("bp_hold", 80'(out_data[4*DW +: DW]), 80'(flit(4'h5, 0, 0)));
      tick();
      chk("bp_hold2", 80'(out_data[4*DW +: DW]), 80'(flit(4'h5, 0, 0)));
      out_ready = 5'h1f;
      for (int s = 1; s < 5; s++) begin
         tick();
         chk($sformatf("bp_drain%0d_vld", s), 80'(out_valid[4]), 80'(1));
         chk($sformatf("bp_drain%0d", s), 80'(out_data[4*DW +: DW]),
             80'(flit(4'h5, 0, s)));
      end
      tick();
      chk("bp_empty", 80'(out_valid[4]), 80'(0));
      chk("bp_ready_back", 80'(in_ready[0]), 80'(1));

      // parallel disjoint streams
      for (int c = 0; c < 7; c++) begin
         if (c < 6) begin
            in_data[0*DW +: DW] = flit(4'h4, 0, c);
            in_data[1*DW +: DW] = flit(4'h0, 1, c);
            in_data[2*DW +: DW] = flit(4'h7, 2, c);
            in_data[3*DW +: DW] = flit(4'hC, 3, c);
            in_data[4*DW +: DW] = flit(4'h5, 4, c);
            in_valid = 5'h1f;
         end else begin
            in_valid = '0;
         end
         tick();
         if (c == 0) begin
            chk("par_fill", 80'(out_valid), 80'(0));
         end else begin
            exp_v = {flit(4'h5, 4, c - 1), flit(4'h0, 1, c - 1),
                     flit(4'h4, 0, c - 1), flit(4'hC, 3, c - 1),
                     flit(4'h7, 2, c - 1)};
            chk($sformatf("par%0d_vld", c), 80'(out_valid), 80'(5'h1f));
            chk($sformatf("par%0d_data", c), out_data, exp_v);
         end
      end
      tick();

      // mid-stream reset
      out_ready = '0;
      for (int c = 0; c < 3; c++) begin
         in_data[0 +: DW] = flit(4'h5, 0, c);
         in_valid = 5'b00001;
         tick();
      end
      in_valid = '0;
      chk("mrst_pre", 80'(out_valid[4]), 80'(1));
      reset = 1'b1;
      in_data[4*DW +: DW] = flit(4'h5, 4, 9);
      in_valid = 5'b10000;
      tick();
      reset = 1'b0;
      in_valid = '0;
      out_ready = 5'h1f;
      chk("mrst_vld", 80'(out_valid), 80'(0));
      chk("mrst_data", out_data, 80'(0));
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("mrst_quiet%0d", c), 80'(out_valid), 80'(0));
      end
      chk("mrst_ready", 80'(in_ready), 80'(5'h1f));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
